// File: rtl/cpu_clkgen_pkg.sv
// rtl/cpu_clkgen_pkg.sv - shared mode encodings, defaults and helpers for cpu_clkgen
//
// Purpose: constants shared by the clock generator top and its pulse sub-module.
//   mode_e         : turbo mode encodings (CPU period = base period >> mode)
//   DIVW_DEFAULT   : default master-clock divider width (16 clocks = 3.5 MHz from 56 MHz)
//   CONTENDED_PAGE : address bits 15:14 of the always-contended 16K page
//   clamp_mode()   : folds an out-of-range turbo request onto the fastest mode
package cpu_clkgen_pkg;

  typedef enum logic [1:0] {
    MODE_3M5 = 2'd0,
    MODE_7M  = 2'd1,
    MODE_14M = 2'd2
  } mode_e;

  localparam int         DIVW_DEFAULT   = 4;
  localparam logic [1:0] CONTENDED_PAGE = 2'b01;

  function automatic logic [1:0] clamp_mode(input logic [1:0] req, input int nmodes);
    if (int'(req) >= nmodes) begin
      return 2'(nmodes - 1);
    end
    return req;
  endfunction

endpackage

// File: rtl/cpu_clkgen_pulse.sv
// rtl/cpu_clkgen_pulse.sv - counter-bit compare giving a rising/falling enable pair
//
// Purpose: for divider tap k, flags the counter values that start each half
// of a 2^(k+1)-clock period. Purely combinational; the caller registers it.
// Ports:
//   cc_i : counter value the pulses are decoded from (DIVW bits)
//   k_i  : tap index, 0..DIVW-1
//   pe_o : cc[k-1:0]==0 and cc[k]==1 (rising-phase point)
//   ne_o : cc[k:0]==0 (falling-phase point)
module clk_pulse #(
  parameter int DIVW = 4,
  parameter int KW   = $clog2(DIVW)
) (
  input  logic [DIVW-1:0] cc_i,
  input  logic [KW-1:0]   k_i,
  output logic            pe_o,
  output logic            ne_o
);

  localparam logic [DIVW:0] ONE = (DIVW + 1)'(1);

  logic [DIVW:0] cc_x;
  logic [DIVW:0] lo_mask;  // bits strictly below k
  logic [DIVW:0] hi_mask;  // bits up to and including k

  always_comb begin
    cc_x    = {1'b0, cc_i};
    lo_mask = (ONE << k_i) - ONE;
    hi_mask = {lo_mask[DIVW-1:0], 1'b1};
    pe_o    = ((cc_x & lo_mask) == '0) && ((cc_x & hi_mask & ~lo_mask) != '0);
    ne_o    = ((cc_x & hi_mask) == '0);
  end

endmodule

// File: rtl/cpu_clkgen.sv
// rtl/cpu_clkgen.sv - master-clock divider producing peripheral and turbo CPU enables with contention
//
// Purpose: divides the 56 MHz master clock into 7 MHz and 3.5 MHz enable pairs
// and a CPU enable pair at 3.5/7/14 MHz, withholding CPU enables while the
// video logic contends for memory or I/O.
// Ports:
//   clock, reset   : master clock, synchronous active-high reset
//   power          : run enable; low freezes all state and silences enables
//   turbo          : requested mode, clamped to NMODES-1
//   mreq, iorq     : CPU strobes, active low
//   a0, ah         : CPU address bit 0 and bits 15:14
//   ramCn          : current paged bank is contended
//   vduCn          : video contention window active
//   pe7M0, ne7M0   : 7 MHz rising/falling enables
//   pe3M5, ne3M5   : 3.5 MHz rising/falling enables (never gated)
//   pc, nc         : CPU rising/falling enables, contention-gated
//   mode           : mode currently applied
//   stall          : a CPU enable is being withheld
module cpu_clkgen
  import cpu_clkgen_pkg::*;
#(
  parameter int DIVW          = DIVW_DEFAULT,
  parameter int NMODES        = 3,
  parameter int CONTEND_TURBO = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       power,
  input  logic [1:0] turbo,
  input  logic       mreq,
  input  logic       iorq,
  input  logic       a0,
  input  logic [1:0] ah,
  input  logic       ramCn,
  input  logic       vduCn,
  output logic       pe7M0,
  output logic       ne7M0,
  output logic       pe3M5,
  output logic       ne3M5,
  output logic       pc,
  output logic       nc,
  output logic [1:0] mode,
  output logic       stall
);

  localparam int KW = $clog2(DIVW);

  logic [DIVW-1:0] cc_q, cc_d;
  logic [1:0]      mode_q, mode_d;
  logic            cpuck_q, cpuck_d;
  logic            iolatch_q, iolatch_d;
  logic            stall_q, stall_d;
  logic            pe7_q, ne7_q, pe3_q, ne3_q, pc_q, nc_q;

  logic [1:0]      req_mode;
  logic            sample_mode;
  logic            mode_switch;
  logic [KW-1:0]   k_cpu;
  logic            raw_pe7, raw_ne7, raw_pe3, raw_ne3, raw_pcpu, raw_ncpu;
  logic            pe7_d, ne7_d, pe3_d, ne3_d, pc_d, nc_d;
  logic            io_fe, contend_active, contend, raw_cpu_edge;

  // Everything decodes from the count the register is about to take, so each
  // registered pulse is high during the cycle the counter sits on its value.
  assign cc_d = power ? cc_q + DIVW'(1) : cc_q;

  // Mode changes only as the count enters zero; every mode has a falling CPU
  // point there, so the new period starts cleanly on the same tick.
  assign req_mode    = clamp_mode(turbo, NMODES);
  assign sample_mode = power && (cc_d == '0);
  assign mode_d      = sample_mode ? req_mode : mode_q;
  assign mode_switch = sample_mode && (req_mode != mode_q);
  assign k_cpu       = KW'(DIVW - 1 - int'(mode_d));

  clk_pulse #(.DIVW(DIVW), .KW(KW)) u_pulse_7m (
    .cc_i (cc_d),
    .k_i  (KW'(DIVW - 2)),
    .pe_o (raw_pe7),
    .ne_o (raw_ne7)
  );

  clk_pulse #(.DIVW(DIVW), .KW(KW)) u_pulse_3m5 (
    .cc_i (cc_d),
    .k_i  (KW'(DIVW - 1)),
    .pe_o (raw_pe3),
    .ne_o (raw_ne3)
  );

  clk_pulse #(.DIVW(DIVW), .KW(KW)) u_pulse_cpu (
    .cc_i (cc_d),
    .k_i  (k_cpu),
    .pe_o (raw_pcpu),
    .ne_o (raw_ncpu)
  );

  // ULA-style contention: io_fe low means an I/O cycle to an even port.
  assign io_fe          = iorq | a0;
  assign contend_active = (mode_d == MODE_3M5) || (CONTEND_TURBO != 0);
  assign contend        = !contend_active ||
                          !(vduCn && cpuck_q && iolatch_q &&
                            ((ah == CONTENDED_PAGE) || ramCn || !io_fe));

  assign pe7_d        = power && raw_pe7;
  assign ne7_d        = power && raw_ne7;
  assign pe3_d        = power && raw_pe3;
  assign ne3_d        = power && raw_ne3;
  assign pc_d         = power && raw_pcpu && contend;
  assign nc_d         = power && raw_ncpu && contend;
  assign raw_cpu_edge = power && (raw_pcpu || raw_ncpu);

  // A withheld edge raises stall; it drops with the next delivered CPU edge,
  // or is discarded when the period is rebuilt by a mode switch.
  assign stall_d   = (raw_cpu_edge && !contend) ||
                     (stall_q && !(pc_d || nc_d) && !mode_switch);
  assign iolatch_d = pc_d  ? (mreq && io_fe)        : iolatch_q;
  assign cpuck_d   = ne7_d ? !(cpuck_q && contend)  : cpuck_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cc_q      <= '0;
      mode_q    <= MODE_3M5;
      cpuck_q   <= 1'b0;
      iolatch_q <= 1'b1;
      stall_q   <= 1'b0;
      pe7_q     <= 1'b0;
      ne7_q     <= 1'b0;
      pe3_q     <= 1'b0;
      ne3_q     <= 1'b0;
      pc_q      <= 1'b0;
      nc_q      <= 1'b0;
    end else begin
      cc_q      <= cc_d;
      mode_q    <= mode_d;
      cpuck_q   <= cpuck_d;
      iolatch_q <= iolatch_d;
      stall_q   <= stall_d;
      pe7_q     <= pe7_d;
      ne7_q     <= ne7_d;
      pe3_q     <= pe3_d;
      ne3_q     <= ne3_d;
      pc_q      <= pc_d;
      nc_q      <= nc_d;
    end
  end

  assign pe7M0 = pe7_q;
  assign ne7M0 = ne7_q;
  assign pe3M5 = pe3_q;
  assign ne3M5 = ne3_q;
  assign pc    = pc_q;
  assign nc    = nc_q;
  assign mode  = mode_q;
  assign stall = stall_q;

endmodule

// File: tb/tb_cpu_clkgen.sv
// tb/tb_cpu_clkgen.sv - self-checking bench for cpu_clkgen against a behavioural model
module tb_cpu_clkgen;

  logic       clock = 1'b0;
  logic       reset, power, mreq, iorq, a0, ramCn, vduCn;
  logic [1:0] turbo, ah;

  logic       pe7_0, ne7_0, pe3_0, ne3_0, pc_0, nc_0, stall_0;
  logic       pe7_1, ne7_1, pe3_1, ne3_1, pc_1, nc_1, stall_1;
  logic [1:0] mode_0, mode_1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk      = 0;

  always #9 clock = ~clock;

  cpu_clkgen #(.DIVW(4), .NMODES(3), .CONTEND_TURBO(0)) dut0 (
    .clock(clock), .reset(reset), .power(power), .turbo(turbo),
    .mreq(mreq), .iorq(iorq), .a0(a0), .ah(ah), .ramCn(ramCn), .vduCn(vduCn),
    .pe7M0(pe7_0), .ne7M0(ne7_0), .pe3M5(pe3_0), .ne3M5(ne3_0),
    .pc(pc_0), .nc(nc_0), .mode(mode_0), .stall(stall_0)
  );

  cpu_clkgen #(.DIVW(4), .NMODES(3), .CONTEND_TURBO(1)) dut1 (
    .clock(clock), .reset(reset), .power(power), .turbo(turbo),
    .mreq(mreq), .iorq(iorq), .a0(a0), .ah(ah), .ramCn(ramCn), .vduCn(vduCn),
    .pe7M0(pe7_1), .ne7M0(ne7_1), .pe3M5(pe3_1), .ne3M5(ne3_1),
    .pc(pc_1), .nc(nc_1), .mode(mode_1), .stall(stall_1)
  );

  // Model: cycle position within a 16-clock base period; a pulse is due when
  // the position lands on the start of a half-period of the relevant rate.
  int         m_cnt   [2];
  int         m_md    [2];
  bit         m_cpuck [2];
  bit         m_iol   [2];
  bit         m_stall [2];
  logic [8:0] m_exp   [2];  // {pe7,ne7,pe3,ne3,pc,nc,mode[1:0],stall}

  task automatic model_step(input int i);
    int p, req;
    bit rpe, rne, sw, iofe, act, cont, epc, enc, ep7, en7, ep3, en3, nst;
    if (reset) begin
      m_cnt[i] = 0; m_md[i] = 0; m_cpuck[i] = 0; m_iol[i] = 1; m_stall[i] = 0;
      m_exp[i] = 9'd0;
      return;
    end
    if (!power) begin
      m_exp[i] = {6'b0, 2'(m_md[i]), m_stall[i]};
      return;
    end
    m_cnt[i] = (m_cnt[i] + 1) % 16;
    req = (turbo > 2'd2) ? 2 : int'(turbo);
    sw = 0;
    if (m_cnt[i] == 0) begin
      sw = (req != m_md[i]);
      m_md[i] = req;
    end
    p   = 16 >> m_md[i];
    rpe = (m_cnt[i] % p) == p / 2;
    rne = (m_cnt[i] % p) == 0;
    ep3 = m_cnt[i] == 8;
    en3 = m_cnt[i] == 0;
    ep7 = (m_cnt[i] % 8) == 4;
    en7 = (m_cnt[i] % 8) == 0;
    iofe = iorq | a0;
    act  = (m_md[i] == 0) || (i == 1);
    cont = !(act && vduCn && m_cpuck[i] && m_iol[i] && (ah == 2'b01 || ramCn || !iofe));
    epc  = rpe && cont;
    enc  = rne && cont;
    nst  = ((rpe || rne) && !cont) || (m_stall[i] && !(epc || enc) && !sw);
    if (epc) m_iol[i] = mreq && iofe;
    if (en7) m_cpuck[i] = !(m_cpuck[i] && cont);
    m_stall[i] = nst;
    m_exp[i] = {ep7, en7, ep3, en3, epc, enc, 2'(m_md[i]), nst};
  endtask

  always @(posedge clock) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clock) begin
    logic [8:0] act0, act1;
    if (chk) begin
      act0 = {pe7_0, ne7_0, pe3_0, ne3_0, pc_0, nc_0, mode_0, stall_0};
      act1 = {pe7_1, ne7_1, pe3_1, ne3_1, pc_1, nc_1, mode_1, stall_1};
      n_checks++;
      if (act0 !== m_exp[0]) begin
        n_fail++;
        $display("FAIL model_dut0 t=%0t: got %b expected %b", $time, act0, m_exp[0]);
      end
      n_checks++;
      if (act1 !== m_exp[1]) begin
        n_fail++;
        $display("FAIL model_dut1 t=%0t: got %b expected %b", $time, act1, m_exp[1]);
      end
    end
  end

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  int st0, st1;

  initial begin
    reset = 1; power = 0; turbo = 0; mreq = 1; iorq = 1; a0 = 1;
    ah = 0; ramCn = 0; vduCn = 0;
    cyc(1);
    chk = 1;
    cyc(2);
    expect_eq("reset_state", {pe7_0, ne7_0, pe3_0, ne3_0, pc_0, nc_0, mode_0, stall_0}, 0);

    // free-run, mode 0, no contention
    reset = 0; power = 1;
    cyc(7);
    expect_eq("pe3m5_before_8", pe3_0, 0);
    cyc(1);
    expect_eq("pe3m5_at_8", pe3_0, 1);
    expect_eq("pc_at_8", pc_0, 1);
    cyc(4);
    expect_eq("pe7m0_at_12", pe7_0, 1);
    cyc(4);
    expect_eq("ne_at_0", {ne3_0, nc_0, ne7_0}, 3'b111);

    // turbo requests take effect only as the count wraps to zero
    cyc(5);
    turbo = 1;
    cyc(10);
    expect_eq("mode_held_until_wrap", mode_0, 0);
    cyc(1);
    expect_eq("mode1_at_wrap", mode_0, 1);
    cyc(4);
    expect_eq("mode1_pc_at_4", pc_0, 1);
    turbo = 2;
    cyc(12);
    expect_eq("mode2_at_wrap", mode_0, 2);
    cyc(2);
    expect_eq("mode2_pc_at_2", pc_0, 1);
    turbo = 3;
    cyc(14);
    expect_eq("turbo3_clamp", mode_0, 2);

    // contended page, mode 0
    turbo = 0; reset = 1;
    cyc(1);
    expect_eq("reset_clear", {pe7_0, ne7_0, pe3_0, ne3_0, pc_0, nc_0, mode_0, stall_0}, 0);
    reset = 0; vduCn = 1; mreq = 1; iorq = 1; a0 = 1; ah = 2'b01;
    cyc(8);
    expect_eq("first_pc_free", pc_0, 1);
    cyc(8);
    expect_eq("nc_withheld", {nc_0, stall_0}, 2'b01);

    // power low mid-stall
    power = 0;
    cyc(37);
    expect_eq("power_low_quiet", {pe7_0, ne7_0, pe3_0, ne3_0, pc_0, nc_0}, 0);
    expect_eq("power_low_stall_held", stall_0, 1);
    power = 1;
    cyc(8);
    expect_eq("still_stalled", {pc_0, stall_0}, 2'b01);
    vduCn = 0;
    cyc(8);
    expect_eq("release_on_raw_edge", {nc_0, stall_0}, 2'b10);

    // reset mid-stall
    vduCn = 1;
    cyc(16);
    expect_eq("restall", stall_0, 1);
    reset = 1;
    cyc(1);
    expect_eq("reset_mid_stall", {pe7_0, ne7_0, pe3_0, ne3_0, pc_0, nc_0, mode_0, stall_0}, 0);

    // uncontended page
    reset = 0; ah = 2'b10; ramCn = 0;
    st0 = 0;
    for (int j = 0; j < 32; j++) begin
      cyc(1);
      st0 += int'(stall_0);
    end
    expect_eq("no_stall_page2", st0, 0);

    // turbo mode contention only in the CONTEND_TURBO build
    reset = 1;
    cyc(1);
    reset = 0; turbo = 1; ah = 2'b01;
    st0 = 0; st1 = 0;
    for (int j = 0; j < 64; j++) begin
      cyc(1);
      st0 += int'(stall_0);
      st1 += int'(stall_1);
    end
    expect_eq("turbo_no_contend", st0, 0);
    expect_eq("turbo_contend_build", st1 > 0, 1);

    // randomized run
    for (int j = 0; j < 4000; j++) begin
      reset = ($urandom_range(0, 299) == 0);
      power = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) turbo = 2'($urandom);
      if ($urandom_range(0, 7) == 0) vduCn = ~vduCn;
      mreq  = ($urandom_range(0, 2) != 0);
      iorq  = ($urandom_range(0, 3) != 0);
      a0    = 1'($urandom);
      ah    = 2'($urandom);
      ramCn = ($urandom_range(0, 3) == 0);
      cyc(1);
    end

    chk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_clkgen.md
Name: cpu_clkgen

Overview:
- Parametrised successor to the fixed 3.5 MHz clock-enable and ULA contention logic in the machine top level.
- From the 56 MHz master clock it produces the video/peripheral 7 MHz and 3.5 MHz enable pulses.
- It also produces CPU enables at a selectable turbo rate: 3.5, 7 or 14 MHz.
- Applies Spectrum-style memory/IO contention, configurable per mode, and switches turbo mode glitch-free on a base-period boundary.

Parameters:
- DIVW, 4, master-clock divider width; base CPU period = 2^DIVW master clocks (16 → 3.5 MHz from 56 MHz).
- NMODES, 3, number of turbo modes; mode m gives CPU period 2^(DIVW-m); requires NMODES ≤ DIVW-1.
- CONTEND_TURBO, 0, 1 = apply contention in every mode; 0 = contention only in mode 0.

Ports:
- clock  in  1  master clock, 56 MHz, posedge.
- reset  in  1  synchronous, active-high.
- power  in  1  run enable; low freezes counter, forces all enables low.
- turbo  in  2  requested mode; values ≥ NMODES clamp to NMODES-1.
- mreq  in  1  CPU MREQ, active low.
- iorq  in  1  CPU IORQ, active low.
- a0  in  1  CPU address bit 0.
- ah  in  2  CPU address bits 15:14.
- ramCn  in  1  memory mapper: current paged bank is contended.
- vduCn  in  1  video: contention window active.
- pe7M0  out  1  7 MHz rising-phase enable.
- ne7M0  out  1  7 MHz falling-phase enable.
- pe3M5  out  1  3.5 MHz rising-phase enable, ungated.
- ne3M5  out  1  3.5 MHz falling-phase enable, ungated.
- pc  out  1  CPU rising enable, mode rate, contention-gated.
- nc  out  1  CPU falling enable, mode rate, contention-gated.
- mode  out  2  currently applied mode.
- stall  out  1  high while contention is withholding a CPU enable.

Behaviour:
- Reset values:
  - cc=0, mode=0, cpuck=0, iolatch=1.
  - All enable outputs 0; stall=0.
  - Reset clears everything on the next edge, including mid-cycle and mid-stall; first pulses follow a fresh count from 0.
- Counter:
  - cc (DIVW bits) increments by 1 each clock while power=1, wrapping 2^DIVW-1 → 0.
  - Held when power=0.
- All enables are registered one-clock pulses, asserted only while power=1.
- Peripheral enables (k = DIVW-1 gives 3.5 MHz, k = DIVW-2 gives 7 MHz):
  - pe at cc[k-1:0]==0 and cc[k]==1.
  - ne at cc[k:0]==0.
- CPU enables:
  - Use the same rule with k = DIVW-1-mode.
  - Mode 0 is identical to pe3M5/ne3M5 before gating.
- Mode switch:
  - Clamped turbo is sampled into mode only when cc==0 (the ne3M5 point); ignored otherwise.
  - The new period starts at that same tick, so no shortened or merged CPU phase is ever produced.
  - Pending contention stall is cleared on a switch.
- Contention (active when mode==0 or CONTEND_TURBO=1; otherwise contend=1 always):
  - ioFE = iorq | a0.
  - iolatch ← mreq & ioFE on each pc.
  - cpuck ← !(cpuck & contend) on each ne7M0.
  - contend = !(vduCn & cpuck & iolatch & (ah==2'b01 | ramCn | !ioFE)).
  - pc = raw CPU pe & contend; nc = raw CPU ne & contend.
  - stall = raw CPU pe|ne occurred with contend=0, held until the next delivered pc/nc.
- Boundaries:
  - vduCn falling mid-stall: release at the next raw CPU edge.
  - power low mid-stall: stall held, counter frozen, resumes identically.
  - turbo change during stall: takes effect only at cc==0.

Decomposition:
- Shared package: mode encodings MODE_3M5=0, MODE_7M=1, MODE_14M=2; DIVW default; contended-page constant 2'b01.
- One natural sub-module, clk_pulse: counter-bit compare producing a pe/ne pulse pair for a given k, instantiated three times (7 MHz, 3.5 MHz, CPU).

Test Plan:
- Free-run: reset, power=1, turbo=0, no contention → pe3M5 and pc high at cc=8, ne3M5 and nc at cc=0; 16-clock period; pe7M0/ne7M0 every 8 clocks.
- Turbo: turbo=1 at cc=5 → mode stays 0 until cc=0, then pc every 8 clocks; turbo=2 → every 4; turbo=3 clamps to mode 2.
- Contention: mode 0, vduCn=1, mreq=0, ah=01 → pc withheld, stall=1, for cycles matching the 48K pattern (6,5,4,3,2,1,0,0 T-state delays); ah=10, ramCn=0 → no stall.
- IO contention: iorq=0, a0=0, vduCn=1 → ioFE path stalls; a0=1, ah=00 → none.
- Turbo contention: mode 1, CONTEND_TURBO=0, contended access → zero stalls; rebuild with CONTEND_TURBO=1 → stalls appear.
- Reset/power: power=0 for 37 clocks mid-stall → no pulses, cc frozen; reset mid-stall → all outputs 0 next clock, mode=0.
